div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider for the execute stage of the MIPS pipeline. It takes operand pairs selected by the execute operand mux, where src B may come from the 16→32 immediate extender. It implements DIV/DIVU with a radix-2 restoring algorithm, one quotient bit per cycle, and writes quotient and remainder toward the HI/LO registers. The hazard unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is required to work.
- `clk` input 1: rising-edge clock.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: begin a division; sampled only in IDLE.
- `signed_div` input 1: 1 = DIV (two's complement), 0 = DIVU.
- `a` input WIDTH: dividend, captured on accepted `start`.
- `b` input WIDTH: divisor, captured on accepted `start`.
- `annul` input 1: flush from exception or branch; aborts the operation in flight.
- `busy` output 1: high while in CALC.
- `ready` output 1: one-cycle pulse when `lo` and `hi` become valid.
- `lo` output WIDTH: quotient.
- `hi` output WIDTH: remainder.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start=1` and `annul=0` → capture operands, go to CALC with iteration counter = WIDTH.
  - Signed mode: latch sign_q = a[31]^b[31] and sign_r = a[31], then convert both operands to magnitudes.
- CALC, each cycle:
  - Shift the {rem, quo} pair left by one.
  - Trial-subtract the divisor magnitude from rem.
  - If the difference is non-negative: rem = difference, set quo[0]=1. Otherwise restore rem.
  - Decrement the counter. When the counter reaches 0 → DONE.
- DONE:
  - Apply sign correction: negate quo if sign_q, negate rem if sign_r.
  - Register results into `lo`/`hi`, pulse `ready`, return to IDLE.
- Arithmetic rules:
  - Remainder sign follows the dividend. Quotient truncates toward zero.
  - Internal rem is WIDTH+1 bits so the trial subtract never loses the borrow.
- Divide by zero (defined, not trapped):
  - Unsigned: lo=0xFFFFFFFF, hi=a.
  - Signed: hi=a; lo=0xFFFFFFFF if a ≥ 0, else 0x00000001.
- Signed overflow 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. No flag.
- Boundary conditions:
  - `start` while busy or in DONE: ignored.
  - `annul` in CALC: go to IDLE at the next edge, no `ready` pulse, `lo`/`hi` keep previous values.
  - `annul` in DONE: suppresses the `ready` pulse and the result write.
  - `start` and `annul` in the same IDLE cycle: annul wins, start is dropped.
  - `resetn` low at any time: immediately go to IDLE, all outputs 0, counter cleared. Any in-flight operation is lost.

## Timing
- Reset values: `busy`=0, `ready`=0, `lo`=0, `hi`=0, state IDLE.
- Normal latency: `start` sampled at edge N.
  - `busy` is high from N to N+32, covering 32 CALC cycles.
  - DONE is cycle N+32→N+33. `ready` and valid `lo`/`hi` are visible after edge N+33.
  - Total: 33 cycles start→ready.
- `lo`/`hi` hold their value until the next completed operation.
- Back-to-back: a new `start` is accepted in the cycle after `ready`. The minimum start-to-start spacing is 34 cycles.
- `busy` is never high in the same cycle as `ready`.

## Configuration
- Macro: `DIV_ZERO_FASTPATH_EN`.
- Defined:
  - On an accepted `start` with b==0, go IDLE→DONE directly, skipping CALC.
  - `ready` is visible after edge N+1. `busy` never rises.
  - Results are as defined above.
- Undefined:
  - b==0 runs the full 32 iterations.
  - Results are identical (the restoring algorithm naturally yields them), latency 33 cycles.

## Structure
- Shared package `mips_div_pkg`:
  - State enum `div_state_t` (IDLE/CALC/DONE).
  - `DIV_WIDTH`=32.
  - `DIV_CNT_W`=6.
- Sub-module `div_step`, combinational:
  - Inputs: rem (WIDTH+1), quo, divisor.
  - Outputs: next rem and next quo for one restoring iteration.
  - Instantiated once in `div_unit`; keeps the datapath separately testable.

## Test plan
- DIVU: a=100, b=7, start → after 33 cycles `ready`=1, lo=14, hi=2. `busy` is high for exactly 32 cycles.
- DIV: a=-100 (0xFFFFFF9C), b=7 → lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2). Also a=100, b=-7 → lo=-14, hi=2.
- DIV: a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero:
  - DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5. DIV a=-5, b=0 → lo=1, hi=0xFFFFFFFB.
  - Latency is 1 cycle with `DIV_ZERO_FASTPATH_EN`, 33 cycles without.
- Abort and reset:
  - Start a=1000, b=3 → assert `annul` at CALC cycle 10 → no `ready`, lo/hi unchanged from the prior result (e.g. 14/2). A start in the next cycle is accepted.
  - Assert `resetn` low mid-CALC → outputs 0 immediately.
- Ignored start: pulse `start` with new operands during CALC → ignored, the original result is delivered.
- Same-cycle conflict: `start` together with `annul` in IDLE → no operation begins, `busy` stays 0.

Source files
------------

// File: rtl/mips_div_pkg.sv
// mips_div_pkg: shared definitions for the execute-stage integer divider.
//   div_state_t : divider control states (IDLE / CALC / DONE)
//   DIV_WIDTH   : operand and result width
//   DIV_CNT_W   : iteration counter width (must hold DIV_WIDTH)
package mips_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the execute stage and the divider.
//   start, signed_div, a, b, annul : issued by the pipeline (master)
//   busy, ready, lo, hi            : returned by the divider (slave)
interface div_unit_if
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, signed_div, a, b, annul,
    input  busy, ready, lo, hi
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output busy, ready, lo, hi
  );

endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem      (WIDTH+1) : partial remainder before the step
//   quo      (WIDTH)   : dividend bits still to shift in / quotient bits so far
//   divisor  (WIDTH)   : divisor magnitude
//   rem_next (WIDTH+1) : partial remainder after the step
//   quo_next (WIDTH)   : quotient register after the step
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // One extra bit above the shifted remainder carries the borrow of the trial subtract.
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {2'b00, divisor};
    rem_next = shifted[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      rem_next = diff[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit DIV/DIVU for the MIPS execute stage.
// Restoring division, one quotient bit per cycle; quotient -> lo, remainder -> hi.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : div_unit_if.slave (start, signed_div, a, b, annul in;
//            busy, ready, lo, hi out, all outputs registered)
// Optional feature: define DIV_ZERO_FASTPATH_EN to finish divide-by-zero
// in one cycle (IDLE -> DONE) instead of running all iterations.
module div_unit
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH:0]       rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     divisor;
  logic                 sign_q;
  logic                 sign_r;

  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     quo_next;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 zero_fast;

  assign a_mag = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

`ifdef DIV_ZERO_FASTPATH_EN
  assign zero_fast = (bus.b == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      bus.busy  <= 1'b0;
      bus.ready <= 1'b0;
      bus.lo    <= '0;
      bus.hi    <= '0;
    end else begin
      bus.ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.annul) begin
            sign_q  <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            sign_r  <= bus.signed_div & bus.a[WIDTH-1];
            divisor <= b_mag;
            if (zero_fast) begin
              // Preload what the full iteration would have produced for b == 0.
              rem   <= {1'b0, a_mag};
              quo   <= '1;
              cnt   <= '0;
              state <= DONE;
            end else begin
              rem      <= '0;
              quo      <= a_mag;
              cnt      <= DIV_CNT_W'(WIDTH);
              bus.busy <= 1'b1;
              state    <= CALC;
            end
          end
        end

        CALC: begin
          if (bus.annul) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt - DIV_CNT_W'(1);
            if (cnt == DIV_CNT_W'(1)) begin
              bus.busy <= 1'b0;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          if (!bus.annul) begin
            bus.ready <= 1'b1;
            bus.lo    <= sign_q ? -quo : quo;
            bus.hi    <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end
          state <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit with a cycle-level
// reference model (plain arithmetic results plus a latency countdown).
module tb_div_unit;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic resetn;

  int unsigned checks = 0;
  int unsigned errors = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic rules.
  function automatic void model_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
    if (y == 32'd0) begin
      r = x;
      q = (!s || !x[31]) ? 32'hFFFF_FFFF : 32'd1;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Timing model: 'left' counts edges until the result write (0 = idle).
  int unsigned left = 0;
  logic [31:0] p_lo = '0, p_hi = '0, m_lo = '0, m_hi = '0;
  logic        m_busy = 1'b0, m_ready = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      left = 0; m_busy = 1'b0; m_ready = 1'b0; m_lo = '0; m_hi = '0;
    end else begin
      m_ready = 1'b0;
      if (left == 0) begin
        if (bus.start && !bus.annul) begin
          model_div(bus.a, bus.b, bus.signed_div, p_lo, p_hi);
          left = (FAST && bus.b == 32'd0) ? 1 : 33;
        end
      end else if (bus.annul) begin
        left = 0;
      end else begin
        left--;
        if (left == 0) begin
          m_ready = 1'b1; m_lo = p_lo; m_hi = p_hi;
        end
      end
      m_busy = (left >= 2);
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, bus.busy}, {31'd0, m_busy});
    chk("cyc_ready", {31'd0, bus.ready}, {31'd0, m_ready});
    chk("cyc_lo", bus.lo, m_lo);
    chk("cyc_hi", bus.hi, m_hi);
  end

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(output int unsigned k, output int unsigned bc, output bit seen);
    k = 0; bc = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      if (bus.ready) seen = 1'b1;
      else begin
        if (bus.busy) bc++;
        step(1);
        k++;
      end
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    bus.a = x; bus.b = y; bus.signed_div = s; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic s, input logic [31:0] el, input logic [31:0] eh);
    int unsigned k, bc;
    bit seen;
    issue(x, y, s);
    wait_ready(k, bc, seen);
    chk({nm, "_ready"}, {31'd0, seen}, 32'd1);
    chk({nm, "_lat"}, k, (FAST && y == 32'd0) ? 32'd1 : 32'd33);
    chk({nm, "_busycyc"}, bc, (FAST && y == 32'd0) ? 32'd0 : 32'd32);
    chk({nm, "_lo"}, bus.lo, el);
    chk({nm, "_hi"}, bus.hi, eh);
    step(1);
  endtask

  initial begin
    int unsigned k, bc;
    bit seen;
    logic [31:0] q, r;

    bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0; bus.a = '0; bus.b = '0;
    resetn = 1'b0;

    // Model sanity against hand-computed values.
    model_div(32'd100, 32'd7, 1'b0, q, r);
    chk("model_divu", q, 32'd14);
    chk("model_divu_r", r, 32'd2);
    model_div(32'hFFFF_FF9C, 32'd7, 1'b1, q, r);
    chk("model_div_neg", q, 32'hFFFF_FFF2);
    chk("model_div_neg_r", r, 32'hFFFF_FFFE);
    model_div(32'hFFFF_FFFB, 32'd0, 1'b1, q, r);
    chk("model_dz", q, 32'd1);

    step(2);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    resetn = 1'b1;
    step(1);

    // Main function, back-to-back issue.
    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_op("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_op("div_100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("divu_big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);

    // Divide by zero.
    run_op("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
    run_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB);
    run_op("div_7_0", 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd7);

    // Annul in CALC: no result, previous lo/hi kept, next start accepted.
    run_op("divu_pre", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    issue(32'd1000, 32'd3, 1'b0);
    step(9);
    bus.annul = 1'b1;
    step(1);
    bus.annul = 1'b0;
    chk("annul_calc_busy", {31'd0, bus.busy}, 32'd0);
    chk("annul_calc_lo", bus.lo, 32'd14);
    chk("annul_calc_hi", bus.hi, 32'd2);
    run_op("divu_1000_3", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);

    // Annul in DONE suppresses ready and the write.
    issue(32'd50, 32'd5, 1'b0);
    step(32);
    bus.annul = 1'b1;
    step(1);
    bus.annul = 1'b0;
    chk("annul_done_ready", {31'd0, bus.ready}, 32'd0);
    chk("annul_done_lo", bus.lo, 32'd333);
    chk("annul_done_hi", bus.hi, 32'd1);
    step(2);

    // Start while busy is ignored.
    issue(32'd100, 32'd7, 1'b0);
    step(4);
    bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    wait_ready(k, bc, seen);
    chk("ign_ready", {31'd0, seen}, 32'd1);
    chk("ign_lat", k, 32'd28);
    chk("ign_lo", bus.lo, 32'd14);
    chk("ign_hi", bus.hi, 32'd2);
    step(1);

    // start + annul together in IDLE: nothing begins.
    bus.a = 32'd77; bus.b = 32'd2; bus.start = 1'b1; bus.annul = 1'b1;
    step(1);
    bus.start = 1'b0; bus.annul = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("conflict_busy", {31'd0, bus.busy}, 32'd0);
      step(1);
    end
    chk("conflict_lo", bus.lo, 32'd14);

    // Reset mid-CALC clears outputs immediately.
    issue(32'd1000, 32'd3, 1'b0);
    step(5);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("mid_rst_lo", bus.lo, 32'd0);
    chk("mid_rst_hi", bus.hi, 32'd0);
    step(2);
    resetn = 1'b1;
    step(1);
    run_op("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
